// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared execute-stage types: widths, arbiter states, writeback entry
package exe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       inst;
  } wb_entry_t;

  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/exe_result_fifo.sv
// rtl/exe_result_fifo.sv - divider result buffer with per-slot valid/addr taps
module exe_result_fifo
  import exe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        push,
  input  logic                        pop,
  input  wb_entry_t                   wdata,
  output wb_entry_t                   head,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [REG_ADDR_W*DEPTH-1:0] ent_addr
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A push into a full buffer is only accepted when the head leaves the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr && do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr) assert (!(push && full && !pop));
  end

  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PW'(PW'(i) - rd_ptr)} < count);
      ent_addr[i*REG_ADDR_W +: REG_ADDR_W] = ent_valid[i] ? mem[i].addr : '0;
    end
  end

endmodule

// File: rtl/exe_wb_arbiter.sv
// rtl/exe_wb_arbiter.sv - merges the pipelined ALU lane and buffered divider results
// onto one registered writeback port, stalling the ALU when a divider result starves.
module exe_wb_arbiter
  import exe_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_by_writeback,
  input  logic                            alu_en_in,
  input  logic [REG_ADDR_W-1:0]           alu_addr_in,
  input  logic [XLEN-1:0]                 alu_result_in,
  input  logic [XLEN-1:0]                 alu_pc_in,
  input  logic [XLEN-1:0]                 alu_inst_in,
  input  logic                            div_en_in,
  input  logic [REG_ADDR_W-1:0]           div_addr_in,
  input  logic [XLEN-1:0]                 div_result_in,
  input  logic [XLEN-1:0]                 div_pc_in,
  input  logic [XLEN-1:0]                 div_inst_in,
  output logic                            stall_alu,
  output logic                            div_buf_full,
  output logic                            wb_en,
  output logic                            wb_we,
  output logic [REG_ADDR_W-1:0]           wb_addr,
  output logic [XLEN-1:0]                 wb_data,
  output logic [XLEN-1:0]                 wb_pc,
  output logic [XLEN-1:0]                 wb_inst,
  output logic [BUF_DEPTH-1:0]            pend_valid,
  output logic [REG_ADDR_W*BUF_DEPTH-1:0] pend_addr
);

  localparam int                WAIT_W   = $clog2(STARVE_LIMIT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT - 1);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  wb_entry_t         alu_entry;
  wb_entry_t         div_entry;
  wb_entry_t         head;
  wb_entry_t         sel_entry;
  logic              fifo_empty;
  logic              alu_take;
  logic              drain_take;
  logic              head_take;
  logic              bypass;
  logic              pop;
  logic              push;
  logic              sel_valid;

  assign alu_entry = '{addr: alu_addr_in, data: alu_result_in, pc: alu_pc_in, inst: alu_inst_in};
  assign div_entry = '{addr: div_addr_in, data: div_result_in, pc: div_pc_in, inst: div_inst_in};

  exe_result_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush_by_writeback),
    .push      (push),
    .pop       (pop),
    .wdata     (div_entry),
    .head      (head),
    .full      (div_buf_full),
    .empty     (fifo_empty),
    .ent_valid (pend_valid),
    .ent_addr  (pend_addr)
  );

  always_comb begin
    alu_take   = alu_en_in && !stall_alu;
    drain_take = (state == ST_DRAIN) && !fifo_empty;
    head_take  = !drain_take && !alu_take && !fifo_empty;
    // An idle lane with nothing queued lets a divider result skip the buffer.
    bypass     = fifo_empty && div_en_in && !alu_take;
    pop        = (drain_take || head_take) && !flush_by_writeback;
    push       = div_en_in && !bypass && !flush_by_writeback;
    sel_valid  = drain_take || alu_take || head_take || bypass;

    sel_entry = '0;
    if (drain_take || head_take) sel_entry = head;
    else if (alu_take)           sel_entry = alu_entry;
    else if (bypass)             sel_entry = div_entry;

    wait_next = wait_cnt;
    if (pop || fifo_empty)      wait_next = '0;
    else if (wait_cnt < WAIT_MAX) wait_next = wait_cnt + 1'b1;

    state_next = state;
    case (state)
      ST_NORMAL: if (!fifo_empty && alu_take && wait_cnt >= WAIT_MAX) state_next = ST_DRAIN;
      ST_DRAIN:  if (pop || fifo_empty) state_next = ST_NORMAL;
      default:   state_next = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_by_writeback) begin
      state     <= ST_NORMAL;
      stall_alu <= 1'b0;
      wait_cnt  <= '0;
      wb_en     <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      wb_pc     <= '0;
      wb_inst   <= '0;
    end else begin
      state     <= state_next;
      stall_alu <= (state_next == ST_DRAIN);
      wait_cnt  <= wait_next;
      wb_en     <= sel_valid;
      wb_we     <= sel_valid && writes_reg(sel_entry.addr);
      wb_addr   <= sel_entry.addr;
      wb_data   <= sel_entry.data;
      wb_pc     <= sel_entry.pc;
      wb_inst   <= sel_entry.inst;
    end
  end

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// tb/tb_exe_wb_arbiter.sv - directed scoreboard bench for exe_wb_arbiter
module tb_exe_wb_arbiter;
  import exe_pkg::*;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        we;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        alu_en;
  logic [4:0]  alu_addr;
  logic [31:0] alu_result;
  logic [31:0] alu_pc;
  logic [31:0] alu_inst;
  logic        div_en;
  logic [4:0]  div_addr;
  logic [31:0] div_result;
  logic [31:0] div_pc;
  logic [31:0] div_inst;
  logic        stall_alu;
  logic        div_buf_full;
  logic        wb_en;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic [1:0]  pend_valid;
  logic [9:0]  pend_addr;

  exp_t q[$];
  int   passed;
  int   total;
  logic pair_ok;

  exe_wb_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush_by_writeback (flush),
    .alu_en_in          (alu_en),
    .alu_addr_in        (alu_addr),
    .alu_result_in      (alu_result),
    .alu_pc_in          (alu_pc),
    .alu_inst_in        (alu_inst),
    .div_en_in          (div_en),
    .div_addr_in        (div_addr),
    .div_result_in      (div_result),
    .div_pc_in          (div_pc),
    .div_inst_in        (div_inst),
    .stall_alu          (stall_alu),
    .div_buf_full       (div_buf_full),
    .wb_en              (wb_en),
    .wb_we              (wb_we),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data),
    .wb_pc              (wb_pc),
    .wb_inst            (wb_inst),
    .pend_valid         (pend_valid),
    .pend_addr          (pend_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic drive_alu(input logic en, input logic [4:0] a, input logic [31:0] d);
    alu_en     = en;
    alu_addr   = a;
    alu_result = d;
    alu_pc     = d + 32'h1000;
    alu_inst   = 32'h0000_0013;
  endtask

  task automatic drive_div(input logic en, input logic [4:0] a, input logic [31:0] d);
    div_en     = en;
    div_addr   = a;
    div_result = d;
    div_pc     = d + 32'h2000;
    div_inst   = 32'h0200_4033;
  endtask

  task automatic expect_alu(input logic [4:0] a, input logic [31:0] d);
    q.push_back('{addr: a, data: d, pc: d + 32'h1000, we: (a != 5'd0)});
  endtask

  task automatic expect_div(input logic [4:0] a, input logic [31:0] d);
    q.push_back('{addr: a, data: d, pc: d + 32'h2000, we: (a != 5'd0)});
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wb_en",   64'(wb_en),   64'd1);
      chk("wb_addr", 64'(wb_addr), 64'(e.addr));
      chk("wb_data", 64'(wb_data), 64'(e.data));
      chk("wb_pc",   64'(wb_pc),   64'(e.pc));
      chk("wb_we",   64'(wb_we),   64'(e.we));
    end else begin
      chk("wb_idle_ctl",  64'({wb_en, wb_we, wb_addr, wb_inst}), 64'd0);
      chk("wb_idle_data", 64'({wb_data, wb_pc}), 64'd0);
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_div(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    chk("rst_stall", 64'(stall_alu), 64'd0);
    chk("rst_full",  64'(div_buf_full), 64'd0);
    chk("rst_pend",  64'({pend_valid, pend_addr}), 64'd0);
    rst = 1'b0;
    tick();

    // divider result with idle ALU bypasses the buffer
    drive_div(1'b1, 5'd5, 32'h7);
    expect_div(5'd5, 32'h7);
    tick();
    chk("bypass_pend", 64'(pend_valid), 64'd0);
    chk("bypass_full", 64'(div_buf_full), 64'd0);
    drive_div(1'b0, 5'd0, 32'd0);

    // write to x0 must not set wb_we
    drive_alu(1'b1, 5'd0, 32'hFFFF);
    expect_alu(5'd0, 32'hFFFF);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    tick();

    // starvation: div buffered behind a busy ALU, forced drain after 4 edges
    drive_alu(1'b1, 5'd1, 32'd100);
    drive_div(1'b1, 5'd3, 32'h33);
    expect_alu(5'd1, 32'd100);
    tick();
    chk("starve_pend", 64'($countones(pend_valid)), 64'd1);
    drive_div(1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      drive_alu(1'b1, 5'(k + 1), 32'(100 + k));
      expect_alu(5'(k + 1), 32'(100 + k));
      tick();
      chk("starve_stall", 64'(stall_alu), 64'(k == 4));
    end
    drive_alu(1'b1, 5'd6, 32'd105);
    expect_div(5'd3, 32'h33);
    tick();
    chk("drain_release", 64'(stall_alu), 64'd0);
    expect_alu(5'd6, 32'd105);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    tick();
    chk("drain_pend", 64'(pend_valid), 64'd0);

    // two buffered results fill the FIFO, then push+pop while full, drain in order
    drive_alu(1'b1, 5'd7, 32'd200);
    drive_div(1'b1, 5'd10, 32'hA0);
    expect_alu(5'd7, 32'd200);
    tick();
    drive_alu(1'b1, 5'd8, 32'd201);
    drive_div(1'b1, 5'd11, 32'hB0);
    expect_alu(5'd8, 32'd201);
    tick();
    chk("fill_full", 64'(div_buf_full), 64'd1);
    chk("fill_valid", 64'(pend_valid), 64'd3);
    pair_ok = (pend_addr[4:0] == 5'd10 && pend_addr[9:5] == 5'd11) ||
              (pend_addr[4:0] == 5'd11 && pend_addr[9:5] == 5'd10);
    chk("fill_addr_pair", 64'(pair_ok), 64'd1);
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_div(1'b1, 5'd12, 32'hC0);
    expect_div(5'd10, 32'hA0);
    tick();
    chk("full_pushpop", 64'(div_buf_full), 64'd1);
    drive_div(1'b0, 5'd0, 32'd0);
    expect_div(5'd11, 32'hB0);
    tick();
    expect_div(5'd12, 32'hC0);
    tick();
    chk("drained_full", 64'(div_buf_full), 64'd0);
    chk("drained_pend", 64'(pend_valid), 64'd0);

    // flush with two buffered entries plus a simultaneous pulse and ALU result
    drive_alu(1'b1, 5'd9, 32'd300);
    drive_div(1'b1, 5'd13, 32'hD0);
    expect_alu(5'd9, 32'd300);
    tick();
    drive_alu(1'b1, 5'd14, 32'd301);
    drive_div(1'b1, 5'd15, 32'hE0);
    expect_alu(5'd14, 32'd301);
    tick();
    chk("preflush_full", 64'(div_buf_full), 64'd1);
    flush = 1'b1;
    drive_alu(1'b1, 5'd16, 32'd302);
    drive_div(1'b1, 5'd17, 32'hF0);
    tick();
    chk("flush_pend",  64'({pend_valid, pend_addr}), 64'd0);
    chk("flush_full",  64'(div_buf_full), 64'd0);
    chk("flush_stall", 64'(stall_alu), 64'd0);
    flush = 1'b0;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_div(1'b0, 5'd0, 32'd0);
    tick();

    // reset in the middle of a forced drain
    drive_alu(1'b1, 5'd18, 32'd400);
    drive_div(1'b1, 5'd19, 32'h44);
    expect_alu(5'd18, 32'd400);
    tick();
    drive_div(1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      drive_alu(1'b1, 5'(18 + k), 32'(400 + k));
      expect_alu(5'(18 + k), 32'(400 + k));
      tick();
    end
    chk("pre_rst_stall", 64'(stall_alu), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_drain_stall", 64'(stall_alu), 64'd0);
    chk("rst_drain_full",  64'(div_buf_full), 64'd0);
    chk("rst_drain_pend",  64'({pend_valid, pend_addr}), 64'd0);
    chk("rst_drain_state", 64'(dut.state), 64'(ST_NORMAL));
    rst = 1'b0;
    drive_alu(1'b0, 5'd0, 32'd0);
    tick();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exe_wb_arbiter.md
EXE_WB_ARBITER -- requirements
Module: exe_wb_arbiter

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2, depth of the divider result buffer (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, maximum cycles a buffered divider result may wait before forced drain.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush_by_writeback  input  1  discard all buffered and in-flight results.
REQ-006 SHALL have ports alu_en_in  input  1 / alu_addr_in  input  5 / alu_result_in  input  32 / alu_pc_in  input  32 / alu_inst_in  input  32, one pipelined ALU/mul result per cycle when alu_en_in=1.
REQ-007 SHALL have ports div_en_in  input  1 / div_addr_in  input  5 / div_result_in  input  32 / div_pc_in  input  32 / div_inst_in  input  32, single-cycle divider completion pulse.
REQ-008 SHALL have port stall_alu  output  1  registered request to hold the ALU lane for one cycle.
REQ-009 SHALL have port div_buf_full  output  1  buffer holds BUF_DEPTH entries; divider must not issue.
REQ-010 SHALL have ports wb_en  output  1 / wb_we  output  1 / wb_addr  output  5 / wb_data  output  32 / wb_pc  output  32 / wb_inst  output  32, registered writeback port.
REQ-011 SHALL have ports pend_valid  output  BUF_DEPTH / pend_addr  output  5*BUF_DEPTH, destination registers of buffered divider results for hazard checks.

Function
REQ-012 SHALL capture every div_en_in pulse into the FIFO tail in the same edge, unless flush_by_writeback=1.
REQ-013 SHALL, per cycle, select exactly one writeback source: forced divider drain > ALU lane > FIFO head.
REQ-014 SHALL use a 2-state FSM: NORMAL (ALU priority) and DRAIN (FIFO head priority, stall_alu=1).
REQ-015 SHALL keep a wait counter on the FIFO head, cleared on pop, incremented each cycle head is valid and not popped.
REQ-016 SHALL move NORMAL->DRAIN when wait counter reaches STARVE_LIMIT-1 and alu_en_in=1; stall_alu asserted from next cycle.
REQ-017 SHALL move DRAIN->NORMAL after one pop in DRAIN, or immediately when FIFO empties.
REQ-018 SHALL, when ALU lane idle (alu_en_in=0 or stall_alu=1), pop FIFO head to writeback that cycle.
REQ-019 SHALL register the selected result: wb_en=1 one cycle after selection; wb_we=wb_en and (wb_addr!=0).
REQ-020 SHALL drive wb_addr/wb_data/wb_pc/wb_inst to 0 whenever wb_en=0.
REQ-021 SHALL accept a div_en_in push and pop in the same cycle when full; count unchanged, no loss.
REQ-022 SHALL drop div_en_in pulses arriving while full and not popping; div_buf_full guarantees this never occurs legally (assertion).
REQ-023 SHALL treat empty FIFO with div_en_in=1 and ALU idle as bypass: result written back next cycle, never enqueued.
REQ-024 SHALL use wrap-around pointers of log2(BUF_DEPTH) bits plus a count of log2(BUF_DEPTH)+1 bits.
REQ-025 SHALL, on flush_by_writeback=1, clear FIFO, counter, FSM to NORMAL, and force wb_en=0 and stall_alu=0 next cycle; flush dominates simultaneous pushes and selections.
REQ-026 SHALL, while stall_alu=1, ignore alu_en_in (upstream holds the instruction).

Reset
REQ-027 SHALL on rst=1 set FSM NORMAL, pointers/count/wait counter 0, all outputs 0 at the next edge.
REQ-028 SHALL give rst priority over flush and all data inputs, including mid-drain.

Structure
REQ-029 SHALL take FSM state encodings, register-address width (5) and data width (32) from the shared exe package.
REQ-030 SHALL implement the buffer as one sub-module exe_result_fifo (push/pop/full/empty/head, per-entry valid/addr outputs).

Verification
REQ-031 Bench: div pulse addr=5 data=0x7, ALU idle -> wb_en=1, wb_addr=5, wb_data=0x7 one cycle later, FIFO stays empty.
REQ-032 Bench: div pulse addr=3 with continuous ALU results -> stall_alu=1 at cycle 4 after push, div result written in the stall cycle, ALU resumes.
REQ-033 Bench: two div pulses while ALU busy -> div_buf_full=1, pend_addr shows both; drained in push order.
REQ-034 Bench: ALU result addr=0 data=0xFFFF -> wb_en=1, wb_we=0.
REQ-035 Bench: flush asserted with 2 buffered entries and simultaneous div pulse -> next cycle count=0, wb_en=0, pend_valid=0.
REQ-036 Bench: rst asserted during DRAIN -> next cycle all outputs 0, FSM NORMAL.
